turbo_enc_scheduler: RTL and testbench

- Sequences one LTE-style turbo code block through the dual-encoder datapath: the direct-path FIFO feeds encoder 1, and the interleaver FIFO feeds encoder 2.
- Latches block size, gates bit reads from both FIFOs, counts K systematic bits, then runs trellis termination for encoder 1 and then for encoder 2.
- Drives the output-stream select and signals block completion or abort.
- Sits between the block-level control (start, size) and the encoder wrapper.

---
 rtl/turbo_enc_scheduler_if.sv | 45 ++++
 rtl/turbo_enc_scheduler.sv | 147 ++++++++++++++
 tb/tb_turbo_enc_scheduler.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/turbo_enc_scheduler_if.sv
// Handshake/status bundle between block control, the turbo scheduler and the encoder wrapper.
// Pure wiring, no latency of its own.
// Optional stats outputs appear when TURBO_SCHED_STATS_EN is defined.
interface turbo_enc_scheduler_if #(
    parameter int CNT_W = 13
);
    logic             start;
    logic             k_sel;
    logic             abort;
    logic             fifo1_empty;
    logic             fifo2_empty;
    logic             rd_req;
    logic             enc_en;
    logic             term1;
    logic             term2;
    logic [1:0]       out_sel;
    logic             busy;
    logic             done;
    logic             aborted;
    logic [CNT_W-1:0] bit_cnt;
`ifdef TURBO_SCHED_STATS_EN
    logic [15:0]      blk_cnt;
    logic [15:0]      stall_cnt;

    modport master (
        output start, k_sel, abort, fifo1_empty, fifo2_empty,
        input  rd_req, enc_en, term1, term2, out_sel, busy, done, aborted, bit_cnt,
               blk_cnt, stall_cnt
    );
    modport slave (
        input  start, k_sel, abort, fifo1_empty, fifo2_empty,
        output rd_req, enc_en, term1, term2, out_sel, busy, done, aborted, bit_cnt,
               blk_cnt, stall_cnt
    );
`else
    modport master (
        output start, k_sel, abort, fifo1_empty, fifo2_empty,
        input  rd_req, enc_en, term1, term2, out_sel, busy, done, aborted, bit_cnt
    );
    modport slave (
        input  start, k_sel, abort, fifo1_empty, fifo2_empty,
        output rd_req, enc_en, term1, term2, out_sel, busy, done, aborted, bit_cnt
    );
`endif
endinterface

// File: rtl/turbo_enc_scheduler.sv
// Sequences one turbo code block: K systematic bits, then TAIL_LEN tail cycles per encoder.
// rd_req/enc_en are combinational from state and FIFO flags; all other outputs registered.
// Stalls (no read, no advance) while either FIFO is empty. Optional stats: TURBO_SCHED_STATS_EN.
module turbo_enc_scheduler #(
    parameter int K_SMALL  = 40,
    parameter int K_LARGE  = 6144,
    parameter int CNT_W    = 13,
    parameter int TAIL_LEN = 3
) (
    input  logic                  clk,
    input  logic                  aclr,
    turbo_enc_scheduler_if.slave  bus
);
    localparam int TAIL_W = (TAIL_LEN > 1) ? $clog2(TAIL_LEN) : 1;

    typedef enum logic [2:0] {IDLE, ENCODE, TERM1, TERM2, FIN} state_t;

    state_t           state;
    logic [CNT_W-1:0] k_last;
    logic [CNT_W-1:0] bit_cnt;
    logic [TAIL_W-1:0] tail_cnt;
    logic             term1, term2, busy, done, aborted;
    logic [1:0]       out_sel;
    logic             fifo_ok, accept, take_abort;
`ifdef TURBO_SCHED_STATS_EN
    logic [15:0]      blk_cnt;
    logic [15:0]      stall_cnt;
`endif

    assign fifo_ok    = !bus.fifo1_empty && !bus.fifo2_empty;
    assign take_abort = bus.abort && (state != IDLE);
    assign accept     = (state == ENCODE) && fifo_ok && !bus.abort;

    assign bus.rd_req  = accept;
    assign bus.enc_en  = accept || (((state == TERM1) || (state == TERM2)) && !bus.abort);
    assign bus.term1   = term1;
    assign bus.term2   = term2;
    assign bus.out_sel = out_sel;
    assign bus.busy    = busy;
    assign bus.done    = done;
    assign bus.aborted = aborted;
    assign bus.bit_cnt = bit_cnt;
`ifdef TURBO_SCHED_STATS_EN
    assign bus.blk_cnt   = blk_cnt;
    assign bus.stall_cnt = stall_cnt;
`endif

    // Block FSM: state, counters and registered outputs advance together
    always_ff @(posedge clk) begin
        if (!aclr) begin
            state    <= IDLE;
            k_last   <= CNT_W'(K_SMALL - 1);
            bit_cnt  <= '0;
            tail_cnt <= '0;
            term1    <= 1'b0;
            term2    <= 1'b0;
            out_sel  <= 2'd0;
            busy     <= 1'b0;
            done     <= 1'b0;
            aborted  <= 1'b0;
`ifdef TURBO_SCHED_STATS_EN
            blk_cnt   <= '0;
            stall_cnt <= '0;
`endif
        end else begin
            done    <= 1'b0;
            aborted <= 1'b0;
            if (take_abort) begin
                // bit_cnt deliberately kept so the abort point can be inspected
                state    <= IDLE;
                term1    <= 1'b0;
                term2    <= 1'b0;
                out_sel  <= 2'd0;
                busy     <= 1'b0;
                aborted  <= 1'b1;
                tail_cnt <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        if (bus.start) begin
                            k_last  <= bus.k_sel ? CNT_W'(K_LARGE - 1) : CNT_W'(K_SMALL - 1);
                            bit_cnt <= '0;
                            state   <= ENCODE;
                            out_sel <= 2'd1;
                            busy    <= 1'b1;
`ifdef TURBO_SCHED_STATS_EN
                            stall_cnt <= '0;
`endif
                        end
                    end
                    ENCODE: begin
                        if (accept) begin
                            bit_cnt <= bit_cnt + 1'b1;
                            if (bit_cnt == k_last) begin
                                state    <= TERM1;
                                term1    <= 1'b1;
                                out_sel  <= 2'd2;
                                tail_cnt <= '0;
                            end
                        end
`ifdef TURBO_SCHED_STATS_EN
                        else if (stall_cnt != 16'hFFFF) begin
                            stall_cnt <= stall_cnt + 1'b1;
                        end
`endif
                    end
                    TERM1: begin
                        if (tail_cnt == TAIL_W'(TAIL_LEN - 1)) begin
                            state    <= TERM2;
                            term1    <= 1'b0;
                            term2    <= 1'b1;
                            out_sel  <= 2'd3;
                            tail_cnt <= '0;
                        end else begin
                            tail_cnt <= tail_cnt + 1'b1;
                        end
                    end
                    TERM2: begin
                        if (tail_cnt == TAIL_W'(TAIL_LEN - 1)) begin
                            state    <= FIN;
                            term2    <= 1'b0;
                            out_sel  <= 2'd0;
                            done     <= 1'b1;
                            tail_cnt <= '0;
`ifdef TURBO_SCHED_STATS_EN
                            blk_cnt  <= blk_cnt + 1'b1;
`endif
                        end else begin
                            tail_cnt <= tail_cnt + 1'b1;
                        end
                    end
                    FIN: begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                    default: begin
                        state   <= IDLE;
                        term1   <= 1'b0;
                        term2   <= 1'b0;
                        out_sel <= 2'd0;
                        busy    <= 1'b0;
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_turbo_enc_scheduler.sv
// Directed bench for turbo_enc_scheduler: nominal K=40/K=6144 blocks, stalls, abort, reset, back-to-back.
// Cycle 0 is the cycle start is driven; outputs sampled on the falling edge.
// Stats outputs are checked when TURBO_SCHED_STATS_EN is defined.
module tb_turbo_enc_scheduler;
    logic clk = 1'b0;
    logic aclr;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    turbo_enc_scheduler_if #(.CNT_W(13)) bus ();

    turbo_enc_scheduler dut (
        .clk  (clk),
        .aclr (aclr),
        .bus  (bus)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // modes: 0 nominal, 1 stalls, 2 abort at bit 20, 3 reset in TERM1, 4 back-to-back, 5 abort+start in IDLE
    task automatic run_block(input logic ks, input int mode, input int ncyc);
        int rd = 0, t1 = 0, t2 = 0, both = 0, dn = 0, d1 = -1, d2 = -1, ab = 0, stall_rd = 0;
        @(posedge clk); #1;
        bus.start = 1'b1; bus.k_sel = ks; bus.abort = (mode == 5);
        bus.fifo1_empty = 1'b0; bus.fifo2_empty = 1'b0; aclr = 1'b1;
        for (int c = 1; c <= ncyc; c++) begin
            @(posedge clk); #1;
            bus.start = 1'b0; bus.k_sel = 1'b0; bus.abort = 1'b0;
            bus.fifo1_empty = 1'b0; bus.fifo2_empty = 1'b0; aclr = 1'b1;
            if (mode == 0 && !ks && c == 42) bus.fifo1_empty = 1'b1;
            if (mode == 1 && c >= 11 && c <= 15) bus.fifo2_empty = 1'b1;
            if (mode == 1 && (c == 30 || c == 31)) bus.fifo1_empty = 1'b1;
            if (mode == 2 && c == 21) bus.abort = 1'b1;
            if (mode == 3 && c == 10) begin bus.start = 1'b1; bus.k_sel = 1'b1; end
            if (mode == 3 && c == 42) aclr = 1'b0;
            if (mode == 4 && c == 48) bus.start = 1'b1;
            @(negedge clk);
            rd += int'(bus.rd_req);
            t1 += int'(bus.term1);
            t2 += int'(bus.term2);
            if (bus.term1 && bus.term2) both++;
            ab += int'(bus.aborted);
            if (bus.done) begin
                dn++;
                if (d1 < 0) d1 = c; else d2 = c;
            end
            if (mode == 0 && !ks) begin
                if (c == 1)  begin check("enc_out_sel", bus.out_sel, 1); check("enc_busy", bus.busy, 1); check("enc_rd", bus.rd_req, 1); end
                if (c == 40) check("last_bit_rd", bus.rd_req, 1);
                if (c == 41) begin check("t1_out_sel", bus.out_sel, 2); check("t1_rd", bus.rd_req, 0); check("t1_en", bus.enc_en, 1); end
                if (c == 42) begin check("t1_empty_en", bus.enc_en, 1); check("t1_empty_rd", bus.rd_req, 0); end
                if (c == 44) begin check("t2_out_sel", bus.out_sel, 3); check("t2_term2", bus.term2, 1); check("t2_en", bus.enc_en, 1); end
                if (c == 47) begin check("fin_busy", bus.busy, 1); check("fin_out_sel", bus.out_sel, 0); check("fin_bit_cnt", bus.bit_cnt, 40); end
                if (c == 48) begin check("idle_busy", bus.busy, 0); check("idle_done", bus.done, 0); end
            end
            if (mode == 0 && ks && c == 6152) check("klarge_busy_after", bus.busy, 0);
            if (mode == 1) begin
                if ((c >= 11 && c <= 15) || c == 30 || c == 31) stall_rd += int'(bus.rd_req);
                if (c == 15) check("stall_bit_hold", bus.bit_cnt, 10);
            end
            if (mode == 2) begin
                if (c == 21) begin check("abort_rd", bus.rd_req, 0); check("abort_en", bus.enc_en, 0); end
                if (c == 22) begin check("aborted_pulse", bus.aborted, 1); check("abort_busy", bus.busy, 0); check("abort_bit_cnt", bus.bit_cnt, 20); check("abort_out_sel", bus.out_sel, 0); end
                if (c == 23) check("aborted_one_cyc", bus.aborted, 0);
            end
            if (mode == 3) begin
                if (c == 41) begin check("busy_start_ign_t1", bus.term1, 1); check("busy_start_ign_cnt", bus.bit_cnt, 40); end
                if (c == 43) begin
                    check("rst_busy", bus.busy, 0); check("rst_term1", bus.term1, 0); check("rst_out_sel", bus.out_sel, 0);
                    check("rst_bit_cnt", bus.bit_cnt, 0); check("rst_en", bus.enc_en, 0); check("rst_rd", bus.rd_req, 0);
                end
            end
            if (mode == 5 && c == 1) begin check("startwins_busy", bus.busy, 1); check("startwins_ab", bus.aborted, 0); end
        end
        check($sformatf("term_overlap_m%0d", mode), both, 0);
        case (mode)
            0, 5: begin
                check($sformatf("rd_total_m%0d", mode), rd, ks ? 6144 : 40);
                check($sformatf("done_cyc_m%0d", mode), d1, ks ? 6151 : 47);
                check($sformatf("done_cnt_m%0d", mode), dn, 1);
                check($sformatf("t1_cnt_m%0d", mode), t1, 3);
                check($sformatf("t2_cnt_m%0d", mode), t2, 3);
            end
            1: begin
                check("stall_rd_total", stall_rd, 0);
                check("stall_rd_count", rd, 40);
                check("stall_done_cyc", d1, 54);
`ifdef TURBO_SCHED_STATS_EN
                check("stall_cnt", bus.stall_cnt, 7);
`endif
            end
            2: begin
                check("abort_no_done", dn, 0);
                check("abort_cnt", ab, 1);
                check("abort_rd_total", rd, 20);
            end
            3: check("rst_no_done", dn, 0);
            4: begin
                check("b2b_done_cnt", dn, 2);
                check("b2b_done1", d1, 47);
                check("b2b_done2", d2, 95);
`ifdef TURBO_SCHED_STATS_EN
                check("blk_cnt", bus.blk_cnt, 2);
`endif
            end
            default: ;
        endcase
    endtask

    initial begin
        bus.start = 1'b0; bus.k_sel = 1'b0; bus.abort = 1'b0;
        bus.fifo1_empty = 1'b0; bus.fifo2_empty = 1'b0;
        aclr = 1'b0;
        repeat (2) @(posedge clk);
        #1 aclr = 1'b1;
        @(negedge clk);
        check("reset_busy", bus.busy, 0);
        check("reset_done", bus.done, 0);
        check("reset_out_sel", bus.out_sel, 0);
        check("reset_bit_cnt", bus.bit_cnt, 0);
        check("reset_rd", bus.rd_req, 0);
        check("reset_en", bus.enc_en, 0);
        @(posedge clk); #1 bus.abort = 1'b1;
        @(posedge clk); #1 bus.abort = 1'b0;
        @(negedge clk);
        check("idle_abort_ignored", bus.aborted, 0);
        check("idle_abort_busy", bus.busy, 0);

        run_block(1'b0, 0, 50);
        run_block(1'b0, 1, 60);
        run_block(1'b0, 2, 30);
        run_block(1'b0, 0, 50);
        run_block(1'b0, 5, 50);
        run_block(1'b1, 0, 6155);
        run_block(1'b0, 3, 45);
        run_block(1'b0, 4, 100);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
